// File: rtl/rle_decomp_unit_pkg.sv
// Shared RLE definitions: token field layout, output word geometry and the
// decompressor FSM state encoding, plus the lane-count helper.
package rle_decomp_unit_pkg;

    localparam int TOKEN_W    = 16;
    localparam int VAL_MSB    = 15;
    localparam int VAL_LSB    = 8;
    localparam int LEN_MSB    = 7;
    localparam int LEN_LSB    = 0;
    localparam int WORD_BYTES = 4;

    // Decompressor state; exposed inside the top as r_state for probing.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_FLUSH  = 2'd2
    } rle_state_t;

    // Bytes that can be written this cycle: min(remaining run, free lanes).
    function automatic logic [2:0] lane_count(input logic [7:0] rem,
                                              input logic [2:0] fill);
        logic [2:0] room;
        room = 3'(WORD_BYTES) - fill;
        if (rem < {5'd0, room})
            lane_count = rem[2:0];
        else
            lane_count = room;
    endfunction

endpackage

// File: rtl/rle_decomp_unit_packer.sv
// Lane-write/merge: copies cur_val into byte lanes fill..fill+n-1 of acc and
// flags when that completes a full output word.
module rle_byte_packer
    import rle_decomp_unit_pkg::*;
(
    input  logic [31:0] i_acc,
    input  logic [2:0]  i_fill,
    input  logic [7:0]  i_cur_val,
    input  logic [2:0]  i_n,
    output logic [31:0] o_acc_next,
    output logic        o_word_full
);

    logic [3:0] w_end;

    // Overwrite the lanes covered by this cycle's bytes, keep the rest.
    always_comb begin
        w_end       = {1'b0, i_fill} + {1'b0, i_n};
        o_acc_next  = i_acc;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if ((4'(i) >= {1'b0, i_fill}) && (4'(i) < w_end))
                o_acc_next[8*i +: 8] = i_cur_val;
        end
        o_word_full = (w_end == 4'(WORD_BYTES));
    end

endmodule

// File: rtl/rle_decomp_unit.sv
// RLE decompressor: expands {value, run_len} tokens into a byte stream packed
// four bytes per word, with a flush path that emits a trailing partial word.
module rle_decomp_unit
    import rle_decomp_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [TOKEN_W-1:0] token_in,
    input  logic               token_valid,
    output logic               token_ready,
    input  logic               flush,
    output logic [31:0]        dout,
    output logic [2:0]         dout_bytes,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               done
);

    // Handshakes: a token moves when token_valid & token_ready at a rising
    // edge; a word moves when dout_valid & dout_ready at a rising edge.
    // dout/dout_bytes stay stable while dout_valid is high and unaccepted.

    rle_state_t  r_state;
    logic [7:0]  r_cur_val;
    logic [7:0]  r_rem;
    logic [31:0] r_acc;
    logic [2:0]  r_fill;
    logic        r_flush_pend;
    logic [31:0] r_dout;
    logic [2:0]  r_dout_bytes;
    logic        r_dout_valid;
    logic        r_done;

    logic        w_out_free;
    logic        w_tok_accept;
    logic [2:0]  w_n;
    logic [31:0] w_acc_next;
    logic        w_word_full;
    logic [7:0]  w_tok_val;
    logic [7:0]  w_tok_len;

    assign w_tok_val    = token_in[VAL_MSB:VAL_LSB];
    assign w_tok_len    = token_in[LEN_MSB:LEN_LSB];
    assign w_out_free   = ~r_dout_valid | dout_ready;
    assign token_ready  = (r_state == ST_IDLE) & ~r_flush_pend & ~flush;
    assign w_tok_accept = token_valid & token_ready;
    assign w_n          = lane_count(r_rem, r_fill);

    assign dout       = r_dout;
    assign dout_bytes = r_dout_bytes;
    assign dout_valid = r_dout_valid;
    assign done       = r_done;

    rle_byte_packer u_packer (
        .i_acc       (r_acc),
        .i_fill      (r_fill),
        .i_cur_val   (r_cur_val),
        .i_n         (w_n),
        .o_acc_next  (w_acc_next),
        .o_word_full (w_word_full)
    );

    // Control FSM with the packing buffer and registered output word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cur_val    <= 8'd0;
            r_rem        <= 8'd0;
            r_acc        <= 32'd0;
            r_fill       <= 3'd0;
            r_flush_pend <= 1'b0;
            r_dout       <= 32'd0;
            r_dout_bytes <= 3'd0;
            r_dout_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_dout_valid && dout_ready)
                r_dout_valid <= 1'b0;
            if (flush)
                r_flush_pend <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (r_flush_pend || flush) begin
                        r_state <= ST_FLUSH;
                    end else if (w_tok_accept) begin
                        r_cur_val <= w_tok_val;
                        r_rem     <= w_tok_len;
                        if (w_tok_len != 8'd0)
                            r_state <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    // A completed word with the output still occupied stalls.
                    if (!(w_word_full && !w_out_free)) begin
                        if (w_word_full) begin
                            r_dout       <= w_acc_next;
                            r_dout_bytes <= 3'd4;
                            r_dout_valid <= 1'b1;
                            r_acc        <= 32'd0;
                            r_fill       <= 3'd0;
                        end else begin
                            r_acc  <= w_acc_next;
                            r_fill <= r_fill + w_n;
                        end
                        r_rem <= r_rem - {5'd0, w_n};
                        if (r_rem == {5'd0, w_n})
                            r_state <= (r_flush_pend || flush) ? ST_FLUSH : ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (r_fill == 3'd0) begin
                        r_flush_pend <= flush;
                        r_done       <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else if (w_out_free) begin
                        r_dout       <= r_acc;
                        r_dout_bytes <= r_fill;
                        r_dout_valid <= 1'b1;
                        r_acc        <= 32'd0;
                        r_fill       <= 3'd0;
                        r_flush_pend <= flush;
                        r_done       <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rle_decomp_unit.sv
// Bench for rle_decomp_unit: directed scenarios plus random tokens, checked
// by a byte-stream reference model feeding an expected-word queue.
module tb_rle_decomp_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] token_in;
    logic        token_valid;
    logic        token_ready;
    logic        flush;
    logic [31:0] dout;
    logic [2:0]  dout_bytes;
    logic        dout_valid;
    logic        dout_ready;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [34:0] exp_q[$];
    logic [7:0]  byte_q[$];
    int          exp_done  = 0;
    int          seen_done = 0;
    bit          mon_en    = 1'b0;
    bit          rand_ready = 1'b0;
    bit          ready_val  = 1'b0;

    rle_decomp_unit dut (
        .clk         (clk),
        .reset       (reset),
        .token_in    (token_in),
        .token_valid (token_valid),
        .token_ready (token_ready),
        .flush       (flush),
        .dout        (dout),
        .dout_bytes  (dout_bytes),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .done        (done)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // reference model: a plain byte stream chopped into 4-byte words
    task automatic model_pack(input int k);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < k; i++) w[8*i +: 8] = byte_q.pop_front();
        exp_q.push_back({3'(k), w});
    endtask

    task automatic model_token(input logic [7:0] v, input logic [7:0] len);
        for (int i = 0; i < int'(len); i++) byte_q.push_back(v);
        while (byte_q.size() >= 4) model_pack(4);
    endtask

    task automatic model_flush();
        if (byte_q.size() > 0) model_pack(byte_q.size());
        exp_done++;
    endtask

    // sink ready driver (sole writer of dout_ready)
    initial begin
        dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) dout_ready = ($urandom_range(0, 3) != 0);
            else            dout_ready = ready_val;
        end
    end

    // monitor / scoreboard
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && reset) begin
                if (done) seen_done++;
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_word: got %h expected none", {dout_bytes, dout});
                    end else begin
                        e = exp_q.pop_front();
                        chk("dout_word", {dout_bytes, dout}, e);
                    end
                end
            end
        end
    end

    // driver tasks: entered and left at posedge+1
    task automatic send_token(input logic [7:0] v, input logic [7:0] len);
        int  guard;
        bit  got;
        guard = 0;
        got   = 1'b0;
        token_in    = {v, len};
        token_valid = 1'b1;
        while (!got && guard < 3000) begin
            @(negedge clk);
            if (token_ready) begin
                got = 1'b1;
                model_token(v, len);
            end
            guard++;
        end
        if (!got) chk("token_accept_timeout", 35'(got), 35'd1);
        @(posedge clk);
        #1;
        token_valid = 1'b0;
    endtask

    task automatic do_flush();
        int guard;
        bit got;
        bit early;
        guard = 0;
        got   = 1'b0;
        early = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        model_flush();
        while (!got && guard < 3000) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else if (token_ready) early = 1'b1;
            guard++;
        end
        chk("done_pulse", 35'(got), 35'd1);
        chk("no_accept_until_done", 35'(early), 35'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_empty", 35'(exp_q.size()), 35'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int guard;
        logic [7:0] v;
        logic [7:0] len;

        reset       = 1'b0;
        token_in    = 16'd0;
        token_valid = 1'b0;
        flush       = 1'b0;

        // reset values
        #12;
        chk("rst_dout", 35'(dout), 35'd0);
        chk("rst_dout_bytes", 35'(dout_bytes), 35'd0);
        chk("rst_dout_valid", 35'(dout_valid), 35'd0);
        chk("rst_done", 35'(done), 35'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 35'(token_ready), 35'd1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // single full word
        ready_val = 1'b1;
        send_token(8'h41, 8'd4);
        @(negedge clk);
        chk("busy_while_expanding", 35'(token_ready), 35'd0);
        @(negedge clk);
        chk("ready_after_word", 35'(token_ready), 35'd1);
        chk("word_41", {dout_valid, dout_bytes, dout}, {1'b1, 3'd4, 32'h41414141});
        @(posedge clk);
        #1;

        // two tokens then flush with a one-byte tail
        send_token(8'h11, 8'd3);
        send_token(8'h22, 8'd2);
        do_flush();
        drain();

        // long run: 64 expand cycles, then three-byte tail
        send_token(8'hAB, 8'd255);
        cnt   = 0;
        guard = 0;
        while (guard < 1000) begin
            @(negedge clk);
            if (token_ready) break;
            cnt++;
            guard++;
        end
        chk("expand_cycles_255", 35'(cnt), 35'd64);
        @(posedge clk);
        #1;
        do_flush();
        drain();

        // back-pressure hold
        ready_val = 1'b0;
        send_token(8'h55, 8'd8);
        guard = 0;
        while (!dout_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("stall_first_valid", 35'(dout_valid), 35'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", {dout_valid, dout_bytes, dout}, {1'b1, 3'd4, 32'h55555555});
            chk("stall_busy", 35'(token_ready), 35'd0);
        end
        @(posedge clk);
        #1;
        ready_val = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("second_word_next", {dout_valid, dout}, {1'b1, 32'h55555555});
        @(posedge clk);
        #1;
        drain();

        // zero-length token then flush with empty buffer
        send_token(8'h7F, 8'd0);
        do_flush();
        chk("zero_len_no_valid", 35'(dout_valid), 35'd0);
        drain();

        // asynchronous reset in the middle of a run
        send_token(8'h33, 8'd100);
        repeat (8) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_dout", 35'(dout), 35'd0);
        chk("async_rst_bytes", 35'(dout_bytes), 35'd0);
        chk("async_rst_valid", 35'(dout_valid), 35'd0);
        chk("async_rst_done", 35'(done), 35'd0);
        exp_q.delete();
        byte_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_midrun_reset", 35'(token_ready), 35'd1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dout_valid) cnt++;
        end
        chk("no_words_after_reset", 35'(cnt), 35'd0);
        @(posedge clk);
        #1;

        // random tokens with random back-pressure and occasional flushes
        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            v = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0:       len = 8'd0;
                1:       len = 8'($urandom_range(100, 255));
                default: len = 8'($urandom_range(1, 20));
            endcase
            send_token(v, len);
            if ($urandom_range(0, 4) == 0) do_flush();
        end
        do_flush();
        drain();
        rand_ready = 1'b0;
        ready_val  = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        chk("final_queue_empty", 35'(exp_q.size()), 35'd0);
        chk("done_count", 35'(seen_done), 35'(exp_done));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rle_decomp_unit.md
RLE_DECOMP_UNIT -- requirements
Module: rle_decomp_unit

Interface
REQ-001 SHALL have no parameters; byte width 8, output word 4 bytes, token 16 bits, all fixed.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port token_in  input  16  RLE token {value[15:8], run_len[7:0]}, same format the compressor emits.
REQ-005 SHALL have port token_valid  input  1  token_in valid this cycle.
REQ-006 SHALL have port token_ready  output  1  block accepts token this cycle.
REQ-007 SHALL have port flush  input  1  single-cycle request to emit any partial word.
REQ-008 SHALL have port dout  output  32  expanded bytes; first byte in time in dout[7:0], then [15:8], [23:16], [31:24].
REQ-009 SHALL have port dout_bytes  output  3  number of valid bytes in dout, 1..4; unused upper bytes zero.
REQ-010 SHALL have port dout_valid  output  1  dout/dout_bytes valid.
REQ-011 SHALL have port dout_ready  input  1  sink consumes dout when dout_valid & dout_ready.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a flush completes.

Function
REQ-013 SHALL hold state: cur_val[7:0], rem[7:0] (bytes left in current run), acc[31:0] packing buffer, fill[2:0] (0..3), flush_pend, and one output register (dout, dout_bytes, dout_valid).
REQ-014 SHALL use FSM states IDLE (rem==0, no flush pending), EXPAND (rem>0), FLUSH (flush_pend & rem==0); IDLE->EXPAND on accepted token with len>0; EXPAND->IDLE when rem reaches 0 and flush_pend=0, else ->FLUSH; FLUSH->IDLE after partial word handed off or immediately if fill==0.
REQ-015 SHALL drive token_ready = (state==IDLE) & ~flush_pend & ~flush, combinationally.
REQ-016 SHALL, on accepted token, load cur_val<=token_in[15:8], rem<=token_in[7:0]; token with run_len 0 SHALL be accepted and produce no bytes.
REQ-017 SHALL, each EXPAND cycle, write n = min(rem, 4-fill) copies of cur_val into acc byte lanes fill..fill+n-1, then rem<=rem-n.
REQ-018 SHALL, when fill+n==4, transfer the completed word to dout with dout_bytes=4, dout_valid=1, fill<=0, acc<=0, in the same edge.
REQ-019 SHALL stall (no change to rem, acc, fill) any cycle a word completion is needed while dout_valid & ~dout_ready.
REQ-020 SHALL treat the output register as free when ~dout_valid | dout_ready; dout_valid SHALL clear on handoff unless refilled that edge.
REQ-021 SHALL give throughput up to 4 bytes/clock; a 255-byte run with fill=0 and dout_ready=1 SHALL complete in 64 EXPAND cycles.
REQ-022 SHALL latch flush into flush_pend in any state; flush while EXPAND SHALL be serviced after rem reaches 0.
REQ-023 SHALL, in FLUSH with fill>0 and output free, emit acc with dout_bytes=fill, clear fill/acc/flush_pend, pulse done next cycle; with fill==0 SHALL clear flush_pend and pulse done without emitting.
REQ-024 SHALL accept no new token from flush assertion until the done pulse.
REQ-025 SHALL never drop or reorder bytes; total bytes out SHALL equal the sum of run_len of accepted tokens.

Reset
REQ-026 SHALL, on reset low, asynchronously clear dout=0, dout_bytes=0, dout_valid=0, done=0, rem=0, fill=0, acc=0, cur_val=0, flush_pend=0, state=IDLE.
REQ-027 SHALL discard any partial run or word on reset mid-operation; token_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-028 SHALL place token field positions, word byte count (4) and FSM state encodings in a shared package used with the compressor.
REQ-029 SHALL implement the lane-write/merge logic as one sub-module, rle_byte_packer (inputs acc, fill, cur_val, n; outputs next acc and word_full).

Verification
REQ-030 Token {0x41,4}, dout_ready=1 -> one word 0x41414141, dout_bytes=4, token_ready back high next cycle.
REQ-031 Tokens {0x11,3},{0x22,2}, then flush -> words 0x22111111 (bytes 4), then 0x00000022 (bytes 1), done pulse.
REQ-032 Token {0xAB,255}, dout_ready=1 -> 63 words 0xABABABAB then, after flush, 0x00ABABAB bytes 3; 64 EXPAND cycles.
REQ-033 Token {0x55,8} with dout_ready=0 for 5 cycles -> dout holds 0x55555555, no state change, second word follows one cycle after dout_ready rises.
REQ-034 Token {0x7F,0} then flush with fill=0 -> no dout_valid, done pulse only.
REQ-035 Reset low mid-run of {0x33,100} -> all outputs 0 asynchronously, no further words, token_ready=1 after release.
